// File: rtl/mm_line_seq_if.sv
// mm_line_seq_if: bundle of the cache-side transfer handshake and the word-wide
// main-memory beat port used by mm_line_seq.
//
// Modports:
//   master - the line sequencer. It takes transfer requests from the cache FSM
//            and drives the mm0 word port. It is the only master on that port.
//   slave  - the environment: the cache FSM (xfer_*) and the memory (mm_ack/mm_rdata).
//
// Signals:
//   xfer_req/op/faddr/eaddr/wline  request, opcode, fill and victim addresses, victim line
//   xfer_busy/done/rline           busy level, completion pulse, filled line
//   mm_req/we/addr/wdata           beat request, write enable, word address, write data
//   mm_ack/rdata                   beat completion, read data

`timescale 1ns/1ps

interface mm_line_seq_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 8
);
    localparam int unsigned LINE_W = LINE_WORDS * WORD_W;

    logic              xfer_req;
    logic [1:0]        xfer_op;
    logic [ADDR_W-1:0] xfer_faddr;
    logic [ADDR_W-1:0] xfer_eaddr;
    logic [LINE_W-1:0] xfer_wline;
    logic              xfer_busy;
    logic              xfer_done;
    logic [LINE_W-1:0] xfer_rline;

    logic              mm_req;
    logic              mm_we;
    logic [ADDR_W-1:0] mm_addr;
    logic [WORD_W-1:0] mm_wdata;
    logic              mm_ack;
    logic [WORD_W-1:0] mm_rdata;

    modport master (
        input  xfer_req, xfer_op, xfer_faddr, xfer_eaddr, xfer_wline, mm_ack, mm_rdata,
        output xfer_busy, xfer_done, xfer_rline, mm_req, mm_we, mm_addr, mm_wdata
    );

    modport slave (
        output xfer_req, xfer_op, xfer_faddr, xfer_eaddr, xfer_wline, mm_ack, mm_rdata,
        input  xfer_busy, xfer_done, xfer_rline, mm_req, mm_we, mm_addr, mm_wdata
    );
endinterface

// File: rtl/mm_line_seq.sv
// mm_line_seq: moves whole cache lines between the cache FSM and the word-wide main
// memory as LINE_WORDS word beats. Operations: NOP, FILL, EVICT, EVICT_FILL.
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     mm_line_seq_if.master: xfer_* request/response and the mm_* beat port
//   Capture build only (MM_LINE_SEQ_CAPTURE_EN defined):
//   cap_idx   in  4       capture entry select
//   cap_addr  out ADDR_W  address of entry cap_idx (combinational read)
//   cap_data  out WORD_W  data of entry cap_idx (combinational read)
//   cap_cnt   out 5       entries filled, saturates at 16
//   cap_ovf   out 1       sticky: a write beat was dropped because the buffer was full
//
// Optional feature macro: MM_LINE_SEQ_CAPTURE_EN records {mm_addr, mm_wdata} of every
// acked write beat into a 16-entry buffer. Without it the capture logic and ports are absent.

`timescale 1ns/1ps

module mm_line_seq #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mm_line_seq_if.master     bus
`ifdef MM_LINE_SEQ_CAPTURE_EN
    ,
    input  logic [3:0]        cap_idx,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [WORD_W-1:0] cap_data,
    output logic [4:0]        cap_cnt,
    output logic              cap_ovf
`endif
);
    localparam int unsigned       BEAT_W    = $clog2(LINE_WORDS);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_WORDS * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    localparam logic [1:0] OpFill      = 2'b01;
    localparam logic [1:0] OpEvict     = 2'b10;
    localparam logic [1:0] OpEvictFill = 2'b11;

    typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

    state_e                           state_q, state_d;
    logic [BEAT_W-1:0]                beat_q, beat_d;
    logic [1:0]                       op_q, op_d;
    logic [ADDR_W-1:0]                fbase_q, fbase_d;
    logic [ADDR_W-1:0]                ebase_q, ebase_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0] wline_q, wline_d;
    logic [LINE_WORDS-1:0][WORD_W-1:0] rline_q, rline_d;
    logic                             mm_req_q, mm_req_d;
    logic                             mm_we_q, mm_we_d;
    logic [ADDR_W-1:0]                mm_addr_q, mm_addr_d;
    logic [WORD_W-1:0]                mm_wdata_q, mm_wdata_d;
    logic                             busy_q, busy_d;
    logic                             done_q, done_d;
    logic                             beat_ack;
    logic [ADDR_W-1:0]                beat_off;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        op_d     = op_q;
        fbase_d  = fbase_q;
        ebase_d  = ebase_q;
        wline_d  = wline_q;
        rline_d  = rline_q;
        // An ack only counts while a beat is actually being requested.
        beat_ack = mm_req_q & bus.mm_ack;

        unique case (state_q)
            StIdle: begin
                if (bus.xfer_req) begin
                    op_d    = bus.xfer_op;
                    fbase_d = bus.xfer_faddr & ~OFF_MASK;
                    ebase_d = bus.xfer_eaddr & ~OFF_MASK;
                    wline_d = bus.xfer_wline;
                    beat_d  = '0;
                    case (bus.xfer_op)
                        OpFill:               state_d = StFill;
                        OpEvict, OpEvictFill: state_d = StWb;
                        default:              state_d = StDone;
                    endcase
                end
            end
            StWb: begin
                if (beat_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = (op_q == OpEvictFill) ? StFill : StDone;
                    end
                end
            end
            StFill: begin
                if (beat_ack) begin
                    rline_d[beat_q] = bus.mm_rdata;
                    beat_d          = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Beats start one cycle after entering WB/FILL from IDLE, but continue without a
        // gap across the WB -> FILL hand-over.
        mm_req_d   = ((state_d == StWb) || (state_d == StFill)) && (state_q != StIdle);
        mm_we_d    = mm_req_d && (state_d == StWb);
        // Offset is ORed into an aligned base, so it can never carry into the tag.
        beat_off   = {{(ADDR_W - BEAT_W - 2){1'b0}}, beat_d, 2'b00};
        mm_addr_d  = '0;
        if (mm_req_d) begin
            mm_addr_d = ((state_d == StWb) ? ebase_d : fbase_d) | beat_off;
        end
        mm_wdata_d = mm_we_d ? wline_d[beat_d] : '0;
        busy_d     = (state_d == StWb) || (state_d == StFill);
        done_d     = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            beat_q     <= '0;
            op_q       <= '0;
            fbase_q    <= '0;
            ebase_q    <= '0;
            wline_q    <= '0;
            rline_q    <= '0;
            mm_req_q   <= 1'b0;
            mm_we_q    <= 1'b0;
            mm_addr_q  <= '0;
            mm_wdata_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            op_q       <= op_d;
            fbase_q    <= fbase_d;
            ebase_q    <= ebase_d;
            wline_q    <= wline_d;
            rline_q    <= rline_d;
            mm_req_q   <= mm_req_d;
            mm_we_q    <= mm_we_d;
            mm_addr_q  <= mm_addr_d;
            mm_wdata_q <= mm_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.xfer_busy  = busy_q;
    assign bus.xfer_done  = done_q;
    assign bus.xfer_rline = rline_q;
    assign bus.mm_req     = mm_req_q;
    assign bus.mm_we      = mm_we_q;
    assign bus.mm_addr    = mm_addr_q;
    assign bus.mm_wdata   = mm_wdata_q;

`ifdef MM_LINE_SEQ_CAPTURE_EN
    logic [15:0][ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [15:0][WORD_W-1:0] cap_data_q, cap_data_d;
    logic [4:0]              cap_cnt_q, cap_cnt_d;
    logic                    cap_ovf_q, cap_ovf_d;
    logic                    cap_wr;

    always_comb begin
        cap_addr_d = cap_addr_q;
        cap_data_d = cap_data_q;
        cap_cnt_d  = cap_cnt_q;
        cap_ovf_d  = cap_ovf_q;
        cap_wr     = mm_req_q & mm_we_q & bus.mm_ack;
        if (cap_wr) begin
            if (cap_cnt_q[4]) begin
                cap_ovf_d = 1'b1;
            end else begin
                cap_addr_d[cap_cnt_q[3:0]] = mm_addr_q;
                cap_data_d[cap_cnt_q[3:0]] = mm_wdata_q;
                cap_cnt_d                  = cap_cnt_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr_q <= '0;
            cap_data_q <= '0;
            cap_cnt_q  <= '0;
            cap_ovf_q  <= 1'b0;
        end else begin
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
            cap_cnt_q  <= cap_cnt_d;
            cap_ovf_q  <= cap_ovf_d;
        end
    end

    assign cap_addr = cap_addr_q[cap_idx];
    assign cap_data = cap_data_q[cap_idx];
    assign cap_cnt  = cap_cnt_q;
    assign cap_ovf  = cap_ovf_q;
`endif
endmodule

// File: tb/tb_mm_line_seq.sv
// tb_mm_line_seq: self-checking bench for mm_line_seq. Table of transfer vectors with
// hand-computed beat counts and done latency, plus hand sequences for mid-transfer reset
// and (capture build only) the capture buffer.

`timescale 1ns/1ps

module tb_mm_line_seq;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mm_line_seq_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) bus ();

`ifdef MM_LINE_SEQ_CAPTURE_EN
    logic [3:0]  cap_idx = 4'd0;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic [4:0]  cap_cnt;
    logic        cap_ovf;
`endif

    mm_line_seq #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MM_LINE_SEQ_CAPTURE_EN
        ,
        .cap_idx  (cap_idx),
        .cap_addr (cap_addr),
        .cap_data (cap_data),
        .cap_cnt  (cap_cnt),
        .cap_ovf  (cap_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // period: ack on every period-th cycle of mm_req; stray: drive mm_ack=1 while mm_req=0;
    // glitch: cycle (after accept) in which an extra EVICT request is pulsed, 0 = none.
    typedef struct {
        logic [1:0]  op;
        logic [31:0] faddr;
        logic [31:0] eaddr;
        logic [31:0] wbase;
        logic [31:0] rbase;
        int          period;
        bit          stray;
        int          glitch;
        int          exp_wr;
        int          exp_rd;
        int          exp_lat;
    } vec_t;

    // Entered mid-cycle; the next rising edge is the accept edge (cycle 1).
    task automatic run_xfer(input vec_t v, input string tag);
        logic [31:0] fal;
        logic [31:0] eal;
        int nwr, nrd, cyc, ackctr, done_cyc, ndone, busy_err, req_err;
        bit ack_now;
        fal = v.faddr & 32'hFFFF_FFE0;
        eal = v.eaddr & 32'hFFFF_FFE0;
        nwr = 0; nrd = 0; cyc = 0; ackctr = 0; done_cyc = 0; ndone = 0;
        busy_err = 0; req_err = 0;
        bus.xfer_req   = 1'b1;
        bus.xfer_op    = v.op;
        bus.xfer_faddr = v.faddr;
        bus.xfer_eaddr = v.eaddr;
        for (int k = 0; k < 8; k++) bus.xfer_wline[k*32 +: 32] = v.wbase + k;
        bus.mm_ack = 1'b0;
        while (cyc < v.exp_lat + 3) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.xfer_req = (cyc == v.glitch);
            if (cyc == v.glitch) bus.xfer_op = 2'b10;
            if (bus.mm_req === 1'b1) begin
                ack_now = ((ackctr % v.period) == v.period - 1);
                ackctr++;
            end else begin
                ack_now = v.stray;
            end
            bus.mm_ack   = ack_now;
            bus.mm_rdata = v.rbase + nrd;
            @(negedge clk);
            if (bus.xfer_busy !== (cyc < v.exp_lat)) busy_err++;
            if (bus.mm_req !== (cyc >= 2 && cyc < v.exp_lat)) req_err++;
            if (bus.xfer_done === 1'b1) begin
                ndone++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (bus.mm_req === 1'b1 && ack_now) begin
                if (bus.mm_we === 1'b1) begin
                    chk({tag, " wr addr"}, bus.mm_addr, eal + 4 * nwr);
                    chk({tag, " wr data"}, bus.mm_wdata, v.wbase + nwr);
                    nwr++;
                end else begin
                    chk({tag, " rd addr"}, bus.mm_addr, fal + 4 * nrd);
                    nrd++;
                end
            end
        end
        bus.mm_ack   = 1'b0;
        bus.xfer_req = 1'b0;
        chk({tag, " write beats"}, nwr, v.exp_wr);
        chk({tag, " read beats"}, nrd, v.exp_rd);
        chk({tag, " done latency"}, done_cyc, v.exp_lat);
        chk({tag, " done pulses"}, ndone, 1);
        chk({tag, " busy profile errs"}, busy_err, 0);
        chk({tag, " mm_req profile errs"}, req_err, 0);
        if (v.exp_rd > 0) begin
            for (int k = 0; k < 8; k++) begin
                chk({tag, " rline word"}, bus.xfer_rline[k*32 +: 32], v.rbase + k);
            end
        end
    endtask

    vec_t vecs[6];

    initial begin
        vec_t rv;
        // op, faddr, eaddr, wbase, rbase, period, stray, glitch, exp_wr, exp_rd, exp_lat
        vecs[0] = '{2'b01, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 1, 1'b1, 10, 0, 8, 10};
        vecs[1] = '{2'b10, 32'h0, 32'h0000_0040, 32'hA0, 32'h0, 3, 1'b0, 4, 8, 0, 26};
        vecs[2] = '{2'b11, 32'h0000_0200, 32'h0000_0100, 32'hC0DE_0000, 32'h300, 1, 1'b0,
                    0, 8, 8, 18};
        vecs[3] = '{2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1'b1, 1, 0, 0, 1};
        vecs[4] = '{2'b01, 32'hFFFF_FFF7, 32'h0, 32'h0, 32'h55, 2, 1'b1, 7, 0, 8, 18};
        vecs[5] = '{2'b11, 32'h0000_001F, 32'hFFFF_FFE0, 32'h5A5A_0000, 32'h900, 2, 1'b0,
                    0, 8, 8, 34};

        bus.xfer_req = 1'b0; bus.xfer_op = 2'b00; bus.xfer_faddr = '0; bus.xfer_eaddr = '0;
        bus.xfer_wline = '0; bus.mm_ack = 1'b0; bus.mm_rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", bus.xfer_busy, 0);
        chk("reset done", bus.xfer_done, 0);
        chk("reset mm_req", bus.mm_req, 0);
        chk("reset mm_we", bus.mm_we, 0);
        chk("reset mm_addr", bus.mm_addr, 0);
        chk("reset mm_wdata", bus.mm_wdata, 0);
        chk("reset rline lo", bus.xfer_rline[63:0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset at beat 4 of a FILL
        bus.xfer_req = 1'b1; bus.xfer_op = 2'b01; bus.xfer_faddr = 32'h0000_0800;
        @(posedge clk);
        #1;
        bus.xfer_req = 1'b0;
        bus.mm_ack = 1'b1;
        bus.mm_rdata = 32'h77;
        repeat (5) @(posedge clk);
        #1;
        chk("rst: beat4 mm_req", bus.mm_req, 1);
        chk("rst: beat4 addr", bus.mm_addr, 32'h0000_0810);
        chk("rst: partial rline word0", bus.xfer_rline[31:0], 32'h77);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst: mm_req async drop", bus.mm_req, 0);
        chk("rst: busy", bus.xfer_busy, 0);
        chk("rst: mm_addr", bus.mm_addr, 0);
        chk("rst: rline cleared", bus.xfer_rline[127:0], 0);
        bus.mm_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst: no done pulse", bus.xfer_done, 0);
        end
        rv = '{2'b01, 32'h0000_0800, 32'h0, 32'h0, 32'h40, 1, 1'b0, 0, 0, 8, 10};
        run_xfer(rv, "post-reset fill");

`ifdef MM_LINE_SEQ_CAPTURE_EN
        // Reset above cleared the capture buffer; three evicts give 24 write beats.
        rv = '{2'b10, 32'h0, 32'h0000_0400, 32'h1000, 32'h0, 1, 1'b0, 0, 8, 0, 10};
        run_xfer(rv, "cap evict0");
        chk("cap cnt after 8", cap_cnt, 8);
        chk("cap ovf after 8", cap_ovf, 0);
        rv = '{2'b10, 32'h0, 32'h0000_0800, 32'h2000, 32'h0, 1, 1'b0, 0, 8, 0, 10};
        run_xfer(rv, "cap evict1");
        rv = '{2'b10, 32'h0, 32'h0000_0C00, 32'h3000, 32'h0, 1, 1'b0, 0, 8, 0, 10};
        run_xfer(rv, "cap evict2");
        chk("cap cnt saturated", cap_cnt, 16);
        chk("cap ovf sticky", cap_ovf, 1);
        cap_idx = 4'd0;
        #1;
        chk("cap entry0 addr", cap_addr, 32'h400);
        chk("cap entry0 data", cap_data, 32'h1000);
        cap_idx = 4'd8;
        #1;
        chk("cap entry8 addr", cap_addr, 32'h800);
        chk("cap entry8 data", cap_data, 32'h2000);
        cap_idx = 4'd15;
        #1;
        chk("cap entry15 addr", cap_addr, 32'h81C);
        chk("cap entry15 data", cap_data, 32'h2007);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
